// File: rtl/bc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bc_pkg: types and constants shared by the bullsCows game FSM and its  |
// | input controller.                                                     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package bc_pkg;

   localparam int DIGITS       = 4;
   localparam int MAX_ATTEMPTS = 15;
   localparam int ATT_W        = $clog2(MAX_ATTEMPTS + 1);

   typedef enum logic [2:0] {
      IDLE,
      SECRET_J1,
      SECRET_J2,
      GUESS_J1,
      GUESS_J2,
      WIN_J1,
      WIN_J2
   } state_t;

   typedef enum logic [1:0] {
      NONE,
      BAD_DIGIT,
      DUP_DIGIT
   } reject_t;

endpackage
`default_nettype wire

// File: rtl/guess_validator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | guess_validator: checks a 4-digit BCD code for non-decimal digits and |
// | repeated digits (combinational).                                      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module guess_validator
   import bc_pkg::*;
(
   input  logic [4*DIGITS-1:0] code,
   output logic                valid,
   output reject_t             reason
);

   logic [DIGITS-1:0] w_bad;
   logic              w_dup;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_nibble
         assign w_bad[i] = (code[4*i +: 4] > 4'd9);
      end
   endgenerate

   always_comb begin
      w_dup = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         for (int j = i + 1; j < DIGITS; j++) begin
            if (code[4*i +: 4] == code[4*j +: 4]) begin
               w_dup = 1'b1;
            end
         end
      end
   end

   // A non-decimal digit outranks a repetition.
   always_comb begin
      reason = NONE;
      if (|w_bad) begin
         reason = BAD_DIGIT;
      end else if (w_dup) begin
         reason = DUP_DIGIT;
      end
   end

   assign valid = (reason == NONE);

endmodule
`default_nettype wire

// File: rtl/guess_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | guess_sequencer: debounces the confirm button, captures and validates |
// | the switch code, commits or rejects it, counts per-player attempts.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module guess_sequencer
   import bc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int ERR_HOLD_CYCLES = 100_000_000
)(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             confirm,
   input  logic [15:0]      SW,
   input  state_t           current_state,
   output logic             commit,
   output logic [15:0]      commit_value,
   output logic             reject,
   output reject_t          reject_code,
   output logic [ATT_W-1:0] attempts_j1,
   output logic [ATT_W-1:0] attempts_j2
);

   localparam int c_db_w  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int c_err_w = $clog2(ERR_HOLD_CYCLES + 1);
   localparam logic [c_db_w-1:0]  c_db_last  = c_db_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_err_w-1:0] c_err_last = c_err_w'(ERR_HOLD_CYCLES);
   localparam logic [ATT_W-1:0]   c_att_max  = ATT_W'(MAX_ATTEMPTS);

   typedef enum logic [2:0] {
      RELEASE_DB,
      ARMED,
      PRESS_DB,
      CHECK,
      COMMIT,
      ERROR
   } seq_state_t;

   seq_state_t          r_state;
   logic                r_confirm_meta;
   logic                r_confirm_s;
   logic [15:0]         r_sw_meta;
   logic [15:0]         r_sw_s;
   logic [c_db_w-1:0]   r_db_cnt;
   logic [c_err_w-1:0]  r_err_cnt;
   logic                w_valid;
   reject_t             w_reason;

   guess_validator u_validator (
      .code   (commit_value),
      .valid  (w_valid),
      .reason (w_reason)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_confirm_meta <= 1'b0;
         r_confirm_s    <= 1'b0;
         r_sw_meta      <= '0;
         r_sw_s         <= '0;
         r_state        <= RELEASE_DB;
         r_db_cnt       <= '0;
         r_err_cnt      <= '0;
         commit         <= 1'b0;
         commit_value   <= '0;
         reject         <= 1'b0;
         reject_code    <= NONE;
      end else begin
         r_confirm_meta <= confirm;
         r_confirm_s    <= r_confirm_meta;
         r_sw_meta      <= SW;
         r_sw_s         <= r_sw_meta;
         commit         <= 1'b0;

         case (r_state)
            RELEASE_DB: begin
               if (r_confirm_s) begin
                  r_db_cnt <= '0;
               end else if (r_db_cnt == c_db_last) begin
                  r_db_cnt <= '0;
                  r_state  <= ARMED;
               end else begin
                  r_db_cnt <= r_db_cnt + 1'b1;
               end
            end
            ARMED: begin
               if (r_confirm_s) begin
                  r_db_cnt <= '0;
                  r_state  <= PRESS_DB;
               end
            end
            PRESS_DB: begin
               if (!r_confirm_s) begin
                  r_state <= ARMED;
               end else if (r_db_cnt == c_db_last) begin
                  commit_value <= r_sw_s;
                  r_state      <= CHECK;
               end else begin
                  r_db_cnt <= r_db_cnt + 1'b1;
               end
            end
            CHECK: begin
               r_err_cnt <= '0;
               // Outside secret/guess entry the code is only a "continue" press.
               if ((current_state inside {IDLE, WIN_J1, WIN_J2}) || w_valid) begin
                  r_state <= COMMIT;
               end else begin
                  r_state <= ERROR;
               end
            end
            COMMIT: begin
               commit   <= 1'b1;
               r_db_cnt <= '0;
               r_state  <= RELEASE_DB;
            end
            ERROR: begin
               // commit_value is frozen here, so the validator output stays valid.
               if (r_err_cnt == c_err_last) begin
                  reject      <= 1'b0;
                  reject_code <= NONE;
                  r_db_cnt    <= '0;
                  r_state     <= RELEASE_DB;
               end else begin
                  reject      <= 1'b1;
                  reject_code <= w_reason;
                  r_err_cnt   <= r_err_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= RELEASE_DB;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n || (current_state inside {IDLE, SECRET_J1})) begin
         attempts_j1 <= '0;
         attempts_j2 <= '0;
      end else if (commit) begin
         if ((current_state == GUESS_J1) && (attempts_j1 != c_att_max)) begin
            attempts_j1 <= attempts_j1 + 1'b1;
         end
         if ((current_state == GUESS_J2) && (attempts_j2 != c_att_max)) begin
            attempts_j2 <= attempts_j2 + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_guess_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_guess_sequencer: directed self-checking bench for guess_sequencer  |
// | with DEBOUNCE_CYCLES=4 and ERR_HOLD_CYCLES=8.                         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_guess_sequencer;
   import bc_pkg::*;

   logic             clock;
   logic             reset_n;
   logic             confirm;
   logic [15:0]      SW;
   state_t           current_state;
   logic             commit;
   logic [15:0]      commit_value;
   logic             reject;
   reject_t          reject_code;
   logic [ATT_W-1:0] attempts_j1;
   logic [ATT_W-1:0] attempts_j2;

   int n_checks = 0;
   int n_fail   = 0;

   guess_sequencer #(
      .DEBOUNCE_CYCLES (4),
      .ERR_HOLD_CYCLES (8)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .confirm       (confirm),
      .SW            (SW),
      .current_state (current_state),
      .commit        (commit),
      .commit_value  (commit_value),
      .reject        (reject),
      .reject_code   (reject_code),
      .attempts_j1   (attempts_j1),
      .attempts_j2   (attempts_j2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives confirm per cycle (pattern bits first, then held until 'hold'), and
   // records when commit/reject are seen; k is the edge index, edge 0 first
   // sampling the first confirm value.
   task automatic run_press(input logic [31:0] pat, input int plen, input int hold,
                            input int total, output int first_c, output int n_c,
                            output int first_r, output int n_r, output reject_t rc);
      first_c = -1; n_c = 0; first_r = -1; n_r = 0; rc = NONE;
      for (int k = 0; k < total; k++) begin
         confirm = (k < plen) ? pat[k] : (k < hold);
         tick();
         if (commit) begin
            if (first_c < 0) first_c = k;
            n_c++;
         end
         if (reject) begin
            if (first_r < 0) begin
               first_r = k;
               rc      = reject_code;
            end
            n_r++;
         end
      end
      confirm = 1'b0;
   endtask

   initial begin
      int      fc, nc, fr, nr, tot;
      reject_t rc;

      reset_n = 1'b0;
      confirm = 1'b0;
      SW = 16'h0000;
      current_state = IDLE;
      ticks(3);
      chk("reset_commit", 32'(commit), 32'd0);
      chk("reset_value", 32'(commit_value), 32'h0);
      chk("reset_reject", 32'(reject), 32'd0);
      chk("reset_code", 32'(reject_code), 32'(NONE));
      chk("reset_att1", 32'(attempts_j1), 32'd0);
      chk("reset_att2", 32'(attempts_j2), 32'd0);
      reset_n = 1'b1;
      ticks(6);

      // Valid guess, clean press held 20 cycles
      current_state = GUESS_J1;
      SW = 16'h1234;
      ticks(3);
      run_press(32'h0, 0, 20, 30, fc, nc, fr, nr, rc);
      chk("valid_first_commit", 32'(fc), 32'd8);
      chk("valid_n_commit", 32'(nc), 32'd1);
      chk("valid_n_reject", 32'(nr), 32'd0);
      chk("valid_value", 32'(commit_value), 32'h1234);
      chk("valid_att1", 32'(attempts_j1), 32'd1);

      // Bounce 1,0,1,1,0 then stable 1 from edge 5
      SW = 16'h5678;
      ticks(3);
      run_press(32'h0000_000D, 5, 20, 32, fc, nc, fr, nr, rc);
      chk("bounce_first_commit", 32'(fc), 32'd13);
      chk("bounce_n_commit", 32'(nc), 32'd1);
      chk("bounce_value", 32'(commit_value), 32'h5678);
      chk("bounce_att1", 32'(attempts_j1), 32'd2);

      // Bad digit in GUESS_J2
      current_state = GUESS_J2;
      SW = 16'h12A4;
      ticks(3);
      run_press(32'h0, 0, 6, 24, fc, nc, fr, nr, rc);
      chk("bad_n_commit", 32'(nc), 32'd0);
      chk("bad_first_reject", 32'(fr), 32'd8);
      chk("bad_n_reject", 32'(nr), 32'd8);
      chk("bad_code", 32'(rc), 32'(BAD_DIGIT));
      chk("bad_att2", 32'(attempts_j2), 32'd0);
      chk("bad_code_after", 32'(reject_code), 32'(NONE));
      chk("bad_reject_after", 32'(reject), 32'd0);

      // Duplicate digit in SECRET_J1 (also clears the attempt counters)
      current_state = SECRET_J1;
      SW = 16'h1231;
      ticks(3);
      run_press(32'h0, 0, 6, 24, fc, nc, fr, nr, rc);
      chk("dup_n_commit", 32'(nc), 32'd0);
      chk("dup_n_reject", 32'(nr), 32'd8);
      chk("dup_code", 32'(rc), 32'(DUP_DIGIT));
      chk("dup_att1_cleared", 32'(attempts_j1), 32'd0);

      // Bad digit outranks duplicate
      current_state = GUESS_J1;
      SW = 16'hAA12;
      ticks(3);
      run_press(32'h0, 0, 6, 24, fc, nc, fr, nr, rc);
      chk("prio_code", 32'(rc), 32'(BAD_DIGIT));
      chk("prio_n_commit", 32'(nc), 32'd0);
      chk("prio_att1", 32'(attempts_j1), 32'd0);

      // IDLE bypasses validation
      current_state = IDLE;
      SW = 16'hFFFF;
      ticks(3);
      run_press(32'h0, 0, 6, 16, fc, nc, fr, nr, rc);
      chk("idle_n_commit", 32'(nc), 32'd1);
      chk("idle_first_commit", 32'(fc), 32'd8);
      chk("idle_n_reject", 32'(nr), 32'd0);
      chk("idle_value", 32'(commit_value), 32'hFFFF);

      // Sixteen valid guesses saturate attempts_j1 at 15
      current_state = GUESS_J1;
      SW = 16'h0123;
      ticks(3);
      tot = 0;
      for (int p = 0; p < 16; p++) begin
         run_press(32'h0, 0, 6, 16, fc, nc, fr, nr, rc);
         tot += nc;
         if (p == 14) chk("sat_att1_at15", 32'(attempts_j1), 32'd15);
      end
      chk("sat_total_commits", 32'(tot), 32'd16);
      chk("sat_att1", 32'(attempts_j1), 32'd15);

      // Reset during a held press
      confirm = 1'b1;
      ticks(5);
      reset_n = 1'b0;
      ticks(2);
      reset_n = 1'b1;
      nc = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (commit) nc++;
      end
      chk("rst_hold_n_commit", 32'(nc), 32'd0);
      chk("rst_hold_att1", 32'(attempts_j1), 32'd0);
      chk("rst_hold_value", 32'(commit_value), 32'h0);
      confirm = 1'b0;
      ticks(8);
      run_press(32'h0, 0, 20, 30, fc, nc, fr, nr, rc);
      chk("rst_repress_first", 32'(fc), 32'd8);
      chk("rst_repress_n", 32'(nc), 32'd1);
      chk("rst_repress_att1", 32'(attempts_j1), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/guess_sequencer.md
# guess_sequencer

Input controller between the board's raw controls (`confirm` button, 16 switches) and the `bullsCows` game FSM. It synchronizes and debounces the button, captures the switch value, and validates it as a 4-digit decimal code with no repeated digit. It then issues a single-cycle commit to the game FSM or holds a reject indication for the display manager. It also keeps per-player attempt counters.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: cycles the synchronized button must be stable, on press and on release (10 ms at 100 MHz).
- `ERR_HOLD_CYCLES`, 100_000_000: cycles `reject` stays high after an invalid entry.
- `clock` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `confirm` in 1: raw push-button (btnc).
- `SW` in 16: raw switches, digits d3..d0 = SW[15:12]..SW[3:0].
- `current_state` in state_t: game FSM state.
- `commit` out 1: one-cycle pulse that replaces the raw confirm into `bullsCows`.
- `commit_value` out 16: captured code, stable from `commit` until the next capture.
- `reject` out 1: high during the error hold.
- `reject_code` out reject_t: NONE / BAD_DIGIT / DUP_DIGIT.
- `attempts_j1`, `attempts_j2` out 4 each: guesses committed by each player, saturating.

## Operation
- 2-FF synchronizer on `confirm` (gives `confirm_s`) and on `SW` (gives `sw_s`).
- States:
  - RELEASE_DB: wait for `confirm_s`=0 for DEBOUNCE_CYCLES consecutive cycles, then go to ARMED. Any 1 clears the counter.
  - ARMED: on `confirm_s`=1, clear the counter and go to PRESS_DB.
  - PRESS_DB: count cycles while `confirm_s`=1. If it drops before DEBOUNCE_CYCLES, return to ARMED (glitch ignored). On count = DEBOUNCE_CYCLES-1 with `confirm_s`=1, capture `sw_s` into `commit_value` and go to CHECK.
  - CHECK (1 cycle): evaluate `current_state`.
    - IDLE, WIN_J1, WIN_J2: go to COMMIT with no validation.
    - SECRET_*, GUESS_*: validate; go to COMMIT if valid, else to ERROR.
  - COMMIT (1 cycle): `commit`=1, then go to RELEASE_DB.
  - ERROR: `reject`=1 and `reject_code` latched, for ERR_HOLD_CYCLES cycles. Then clear `reject`, set `reject_code`=NONE, and go to RELEASE_DB. Button activity is ignored in this state.
- Validation:
  - BAD_DIGIT if any nibble > 9. This has priority.
  - Otherwise DUP_DIGIT if any of the 6 nibble pairs are equal.
- Attempt counters:
  - On `commit` with `current_state`=GUESS_J1, increment `attempts_j1`; with GUESS_J2, increment `attempts_j2`.
  - Both saturate at 15.
  - Both clear while `current_state` is IDLE or SECRET_J1.
  - Rejected entries do not count.
- Only one commit per physical press; holding the button never repeats.
- `current_state` changing during PRESS_DB or ERROR has no effect. CHECK uses its value at CHECK.

## Timing
- Reset values (`reset_n`=0 at an edge): state RELEASE_DB, counters 0, `commit`=0, `commit_value`=0, `reject`=0, `reject_code`=NONE, attempts 0, synchronizers 0.
- Because reset leaves the block in RELEASE_DB, a button held through reset release produces no commit until it is released and pressed again.
- Reset mid-press or mid-error aborts immediately with no commit and no increment.
- Latency, with `confirm` first sampled 1 at edge 0 and held:
  - `confirm_s`=1 at edge 2.
  - PRESS_DB from edge 3.
  - CHECK at edge 3+DEBOUNCE_CYCLES.
  - `commit` high during the cycle after edge 4+DEBOUNCE_CYCLES (exactly one cycle).
- `reject` rises at the same point `commit` would, and stays high exactly ERR_HOLD_CYCLES cycles.
- The attempt counter updates on the edge that ends the `commit` cycle.
- All outputs are registered.

## Structure
- Shared package `bc_pkg`:
  - `state_t` (IDLE, SECRET_J1, SECRET_J2, GUESS_J1, GUESS_J2, WIN_J1, WIN_J2), moved out of the game FSM so both blocks share it.
  - `reject_t` enum.
  - `DIGITS`=4 and `MAX_ATTEMPTS`=15.
- One sub-module, `guess_validator`: combinational, takes 16-bit code in, gives `valid` and `reject_t` out. It is reusable by the game FSM.
- Counters are sized with `$clog2` of the parameters.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and ERR_HOLD_CYCLES=8.
- Valid guess: SW=16'h1234, GUESS_J1, clean press held 20 cycles -> a single `commit` at cycle 8, `commit_value`=16'h1234, `attempts_j1`=1.
- Bounce: `confirm` pattern 1,0,1,1,0 then stable 1 -> exactly one `commit`, 4+DEBOUNCE_CYCLES cycles after the stable 1 begins.
- Bad digit: SW=16'h12A4, GUESS_J2 -> `reject`=1 for 8 cycles, `reject_code`=BAD_DIGIT, no `commit`, `attempts_j2` unchanged.
- Duplicate digit: SW=16'h1231, SECRET_J1 -> `reject_code`=DUP_DIGIT.
- Priority: SW=16'hAA12 -> `reject_code`=BAD_DIGIT.
- IDLE: SW=16'hFFFF, state IDLE -> `commit` with no reject. Also, 16 valid commits in GUESS_J1 -> `attempts_j1` stays at 15.
- Reset during a held press -> no `commit` after reset release until the button is released (≥4 cycles) and pressed again.
